n2t_bus_arbiter2: RTL and testbench
===================================

// Module: n2t_bus_arbiter2
// PURPOSE
//  Two-requester round-robin arbiter sharing one 16-bit data path toward a single consumer.
//  Requester data is steered by an n2tmux16 instance (sel=0 -> A, sel=1 -> B).
//  The selected word is captured into a registered output stage.
//  Grants are burst-oriented: a winner keeps the path until its last beat or MAX_BURST beats.
//  Sits between producers (e.g. CPU write port, loader) and a shared memory/IO write port.
// PARAMETERS
//  WIDTH      16  data width; must be 16 while the steering mux is n2tmux16
//  MAX_BURST  4   max beats per grant (1..15); beat counter is 4 bits
// PORTS
//  clk        in   1      rising-edge clock (the block's only clock)
//  rst_n      in   1      asynchronous, active-low reset
//  a_valid    in   1      requester A has a beat
//  a_data     in   WIDTH  requester A beat data
//  a_last     in   1      this A beat ends A's burst
//  a_ready    out  1      A beat accepted this cycle (when a_valid=1)
//  b_valid/b_data/b_last/b_ready  same as A, for requester B
//  out_valid  out  1      out_data/out_src hold a beat
//  out_data   out  WIDTH  registered beat
//  out_src    out  1      source of out_data (0=A, 1=B)
//  out_ready  in   1      consumer accepts beat
//  busy       out  1      state != IDLE or out_valid=1
// BEHAVIOUR
//  Reset (async assert, synchronous-edge release):
//   - state=IDLE; last_grant=B, so A has priority first.
//   - beat_cnt=0; out_valid=0, out_data=0, out_src=0; a_ready=b_ready=0; busy=0.
//  FSM states: IDLE, GNT_A, GNT_B. Grant is registered; readies are 0 in IDLE.
//  IDLE:
//   - Only A valid -> GNT_A. Only B valid -> GNT_B.
//   - Both valid -> the requester != last_grant. Neither -> stay in IDLE.
//  GNT_x:
//   - x_ready = !out_valid | out_ready; the other ready = 0.
//   - Handshake (x_valid & x_ready): out_data <= mux(x_data), out_src <= x,
//     out_valid <= 1, beat_cnt += 1.
//   - Burst ends on: (a) handshake with x_last=1; (b) handshake making beat_cnt==MAX_BURST;
//     (c) x_valid=0 while x_ready=1 (requester dropped).
//   - On burst end: last_grant <= x, beat_cnt <= 0.
//     Next state: GNT_other if other_valid, else IDLE. No idle cycle is inserted on handover.
//   - x_valid=0 while x_ready=0 (output stalled) -> hold grant and count.
//  Output stage:
//   - out_valid clears on out_ready when no new handshake occurs in that cycle.
//   - Simultaneous drain + capture -> out_valid stays 1 with the new data.
//   - out_data/out_src are stable while out_valid & !out_ready.
//  Latency: request seen in IDLE at edge N -> x_ready at N+1 -> out_valid at N+2.
//   Sustained throughput is 1 beat/cycle within a grant and across a handover.
//  Fairness: strictly alternating under continuous contention; no starvation beyond MAX_BURST beats.
//  Requesters must hold data/last stable while valid & !ready; the arbiter does not check this.
//  Reset mid-burst: everything clears immediately; an un-drained out beat is discarded.
// TESTING
//  1. Post-reset, a_valid=b_valid=1 held, a_data=0x1111, b_data=0x2222, last=0, out_ready=1
//     -> 4 beats 0x1111 (out_src=0), then 4 beats 0x2222 (out_src=1), repeating, no bubbles.
//  2. Only B valid, 3 beats 0xBEE0..0xBEE2, b_last on the 3rd
//     -> out_valid from edge N+2, beats in order, then IDLE, busy=0 one cycle after drain.
//  3. A burst in flight, out_ready=0 for 5 cycles
//     -> a_ready=0, out_data held at the last captured value.
//     On out_ready=1, streaming resumes with no beat lost or duplicated.
//  4. A single beat with a_last=1 while B is waiting
//     -> GNT_B in the very next cycle; b_ready=1 without an IDLE cycle.
//  5. Assert rst_n=0 mid-burst with out_valid=1
//     -> out_valid, a_ready and busy drop at once.
//     After release, A has priority again when both request.
//  6. A drops a_valid after 2 beats (out_ready=1), B idle
//     -> IDLE next cycle, last_grant=A, so B wins the next contention.

Source files
------------

// File: rtl/n2t_bus_arbiter2.sv
// Two-requester round-robin burst arbiter. Beats are steered through n2tmux16
// and land in a registered output stage.

module n2tmux16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        sel,
  output logic [15:0] out
);
  assign out = sel ? b : a;
endmodule

module n2t_bus_arbiter2 #(
  parameter int WIDTH     = 16,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_last,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_last,
  output logic             b_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_A = 2'd1;
  localparam logic [1:0] GNT_B = 2'd2;

  logic [1:0]       state, state_nxt;
  logic             last_grant, last_grant_nxt;
  logic [3:0]       beat_cnt, beat_cnt_nxt;
  logic             sel, granted, take, x_valid, x_last, x_ready, other_valid;
  logic             hs, burst_end;
  logic [WIDTH-1:0] mux_out;

  n2tmux16 u_mux (
    .a   (a_data),
    .b   (b_data),
    .sel (sel),
    .out (mux_out)
  );

  assign sel         = (state == GNT_B);
  assign granted     = (state == GNT_A) || (state == GNT_B);
  assign take        = !out_valid || out_ready;
  assign a_ready     = (state == GNT_A) && take;
  assign b_ready     = (state == GNT_B) && take;
  assign x_valid     = sel ? b_valid : a_valid;
  assign x_last      = sel ? b_last  : a_last;
  assign other_valid = sel ? a_valid : b_valid;
  assign x_ready     = a_ready || b_ready;
  assign hs          = x_valid && x_ready;
  // A requester that drops valid while it could have been accepted forfeits the grant.
  assign burst_end   = (hs && (x_last || beat_cnt == 4'(MAX_BURST - 1))) ||
                       (granted && !x_valid && x_ready);
  assign busy        = (state != IDLE) || out_valid;

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    beat_cnt_nxt   = beat_cnt;
    if (!granted) begin
      if (a_valid && b_valid) state_nxt = last_grant ? GNT_A : GNT_B;
      else if (a_valid)       state_nxt = GNT_A;
      else if (b_valid)       state_nxt = GNT_B;
    end else if (burst_end) begin
      last_grant_nxt = sel;
      beat_cnt_nxt   = '0;
      if (other_valid) state_nxt = sel ? GNT_A : GNT_B;
      else             state_nxt = IDLE;
    end else if (hs) begin
      beat_cnt_nxt = beat_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      beat_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      beat_cnt   <= beat_cnt_nxt;
    end
  end

  // Capture wins over drain so a same-cycle drain+capture keeps out_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
    end else if (hs) begin
      out_valid <= 1'b1;
      out_data  <= mux_out;
      out_src   <= sel;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_n2t_bus_arbiter2.sv
// Bench for n2t_bus_arbiter2: directed scenarios plus random traffic, each
// cycle compared against a beat-level reference model of the arbitration rules.

module tb_n2t_bus_arbiter2;
  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_valid, a_last, b_valid, b_last, out_ready;
  logic [15:0] a_data, b_data;
  logic        a_ready, b_ready, out_valid, out_src, busy;
  logic [15:0] out_data;

  always #5 clk = ~clk;

  n2t_bus_arbiter2 #(.WIDTH(16), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_last(a_last), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_last(b_last), .b_ready(b_ready),
    .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready), .busy(busy)
  );

  int nvec = 0, nerr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner 0=none 1=A 2=B; last winner 0=A 1=B; beats taken in current grant.
  int          m_owner, m_cnt;
  bit          m_last, m_ov, m_os, m_hsa, m_hsb;
  logic [15:0] m_od;

  function automatic void m_reset();
    m_owner = 0; m_last = 1; m_cnt = 0; m_ov = 0; m_od = '0; m_os = 0;
  endfunction

  function automatic bit m_take();
    return !m_ov || out_ready;
  endfunction

  function automatic void m_step();
    bit take, xv, xl, ov_v, done;
    logic [15:0] xd;
    take = m_take();
    m_hsa = 0; m_hsb = 0; done = 0;
    if (m_owner == 0) begin
      if (out_ready) m_ov = 0;
      if (a_valid && b_valid) m_owner = m_last ? 1 : 2;
      else if (a_valid)       m_owner = 1;
      else if (b_valid)       m_owner = 2;
    end else begin
      xv   = (m_owner == 1) ? a_valid : b_valid;
      xl   = (m_owner == 1) ? a_last  : b_last;
      xd   = (m_owner == 1) ? a_data  : b_data;
      ov_v = (m_owner == 1) ? b_valid : a_valid;
      if (xv && take) begin
        if (m_owner == 1) m_hsa = 1; else m_hsb = 1;
        m_ov = 1; m_od = xd; m_os = (m_owner == 2);
        m_cnt++;
        done = xl || (m_cnt == MAXB);
      end else begin
        if (out_ready) m_ov = 0;
        done = !xv && take;
      end
      if (done) begin
        m_last  = (m_owner == 2);
        m_cnt   = 0;
        m_owner = ov_v ? 3 - m_owner : 0;
      end
    end
  endfunction

  task automatic check_outs();
    chk("a_ready",   a_ready,   (m_owner == 1) && m_take());
    chk("b_ready",   b_ready,   (m_owner == 2) && m_take());
    chk("out_valid", out_valid, m_ov);
    chk("out_data",  out_data,  m_od);
    chk("out_src",   out_src,   m_os);
    chk("busy",      busy,      (m_owner != 0) || m_ov);
  endtask

  task automatic cyc(input bit av, input logic [15:0] ad, input bit al,
                     input bit bv, input logic [15:0] bd, input bit bl, input bit ordy);
    @(negedge clk);
    a_valid = av; a_data = ad; a_last = al;
    b_valid = bv; b_data = bd; b_last = bl; out_ready = ordy;
    #1 check_outs();
    @(posedge clk);
    m_step();
  endtask

  // Sequenced streams: data advances only on acceptance, last is held while pending.
  logic [15:0] a_base, b_base;
  int          a_seq, b_seq;
  bit          a_pend, b_pend, a_lq, b_lq;

  task automatic drive(input bit av, input bit al, input bit bv, input bit bl, input bit ordy);
    bit ale, ble;
    ale = a_pend ? a_lq : al;
    ble = b_pend ? b_lq : bl;
    cyc(av || a_pend, a_base + 16'(a_seq), ale, bv || b_pend, b_base + 16'(b_seq), ble, ordy);
    a_lq = ale; b_lq = ble;
    if (m_hsa) a_seq++;
    if (m_hsb) b_seq++;
    a_pend = (av || a_pend) && !m_hsa;
    b_pend = (bv || b_pend) && !m_hsb;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst a_ready", a_ready, 0);
    chk("rst b_ready", b_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst out_data", out_data, 0);
    chk("rst out_src", out_src, 0);
    chk("rst busy", busy, 0);
    m_reset();
    a_valid = 0; b_valid = 0; a_last = 0; b_last = 0; out_ready = 0;
    a_pend = 0; b_pend = 0; a_seq = 0; b_seq = 0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int k, n;
    rst_n = 1'b0;
    a_valid = 0; b_valid = 0; a_last = 0; b_last = 0; out_ready = 0;
    a_data = '0; b_data = '0;
    a_base = 16'hA000; b_base = 16'hB000;
    do_reset();

    // Continuous contention: 4 A beats then 4 B beats, repeating.
    repeat (20) cyc(1, 16'h1111, 0, 1, 16'h2222, 0, 1);

    // B alone, three beats ending with b_last.
    do_reset();
    b_base = 16'hBEE0;
    cyc(0, 0, 0, 0, 0, 0, 1);
    k = 0; n = 0;
    while (k < 3 && n < 20) begin
      cyc(0, 0, 0, 1, b_base + 16'(k), (k == 2), 1);
      if (m_hsb) k++;
      n++;
    end
    chk("b burst done", k, 3);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 1);

    // A burst with a 5-cycle output stall in the middle.
    do_reset();
    repeat (2) drive(1, 0, 0, 0, 1);
    repeat (5) drive(1, 0, 0, 0, 0);
    repeat (4) drive(1, 0, 0, 0, 1);
    repeat (3) drive(0, 0, 0, 0, 1);

    // Single A beat with last while B waits: immediate handover.
    do_reset();
    drive(1, 1, 1, 0, 1);
    drive(0, 0, 1, 0, 1);
    drive(0, 0, 1, 1, 1);
    repeat (2) drive(0, 0, 0, 0, 1);

    // Reset in the middle of an A burst, then A must win again.
    do_reset();
    repeat (3) drive(1, 0, 0, 0, 1);
    do_reset();
    repeat (4) drive(1, 0, 1, 0, 1);

    // A drops after 2 beats; B then wins the next contention.
    do_reset();
    drive(1, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    drive(1, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1);
    repeat (3) drive(1, 0, 1, 0, 1);

    // Random traffic.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 3) != 0);
      if (i == 300) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
